pio_io_ctrl: RTL and testbench

PIO_IO_CTRL -- requirements
Module: pio_io_ctrl

---
 rtl/pio_io_pkg.sv | 34 +++
 rtl/pio_debounce.sv | 69 ++++++
 rtl/pio_io_ctrl.sv | 123 ++++++++++++
 tb/tb_pio_io_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_io_pkg.sv
// Shared constants for the PIO controller: bus width, register map and edge-capture modes.
// Also holds the edge-qualification helper used by every input channel.
package pio_io_pkg;

    localparam int BUS_WIDTH  = 32;
    localparam int ADDR_WIDTH = 3;

    typedef enum logic [ADDR_WIDTH-1:0] {
        ADDR_DATA_IN  = 3'd0,
        ADDR_DATA_OUT = 3'd1,
        ADDR_IRQ_MASK = 3'd2,
        ADDR_EDGE_CAP = 3'd3,
        ADDR_OUT_SET  = 3'd4,
        ADDR_OUT_CLR  = 3'd5,
        ADDR_RSVD6    = 3'd6,
        ADDR_RSVD7    = 3'd7
    } reg_addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // True when a debounced change from old_val to new_val counts as an event for this mode.
    function automatic logic edge_match(input int mode, input logic old_val, input logic new_val);
        logic hit;
        case (mode)
            EDGE_RISING:  hit = !old_val && new_val;
            EDGE_FALLING: hit = old_val && !new_val;
            default:      hit = old_val != new_val;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pio_debounce.sv
// One input channel: two-flop synchronizer, stable-cycle debounce counter and edge pulse.
// The edge pulse is registered alongside the debounced value, so both change on the same edge.
module pio_debounce
    import pio_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = EDGE_RISING
) (
    input  logic clk,
    input  logic srst,
    input  logic din,
    output logic deb,
    output logic edge_evt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             deb_reg;
    logic             deb_next;
    logic             edge_reg;
    logic             edge_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
        end
    end

    // The counter is cleared on the cycle it would reach DEBOUNCE_CYCLES, so it never wraps.
    always_comb begin
        cnt_next  = cnt_reg;
        deb_next  = deb_reg;
        edge_next = 1'b0;
        if (sync2_reg == deb_reg) begin
            cnt_next = '0;
        end else if (cnt_reg >= CNT_LAST) begin
            cnt_next  = '0;
            deb_next  = sync2_reg;
            edge_next = edge_match(EDGE_MODE, deb_reg, sync2_reg);
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg  <= '0;
            deb_reg  <= 1'b0;
            edge_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            deb_reg  <= deb_next;
            edge_reg <= edge_next;
        end
    end

    assign deb      = deb_reg;
    assign edge_evt = edge_reg;

endmodule

// File: rtl/pio_io_ctrl.sv
// Avalon-MM PIO block: debounced inputs with edge capture and masked interrupt,
// plus a directly driven output register with set/clear shortcuts.
module pio_io_ctrl
    import pio_io_pkg::*;
#(
    parameter int IN_WIDTH        = 3,
    parameter int OUT_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = EDGE_RISING
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic [IN_WIDTH-1:0]   pio_in_export,
    output logic [OUT_WIDTH-1:0]  pio_out_export,
    input  logic [ADDR_WIDTH-1:0] avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [BUS_WIDTH-1:0]  avs_writedata,
    output logic [BUS_WIDTH-1:0]  avs_readdata,
    output logic                  avs_readdatavalid,
    output logic                  irq
);

    logic [IN_WIDTH-1:0]  data_in;
    logic [IN_WIDTH-1:0]  edge_evt;

    logic [OUT_WIDTH-1:0] data_out_reg;
    logic [OUT_WIDTH-1:0] data_out_next;
    logic [IN_WIDTH-1:0]  irq_mask_reg;
    logic [IN_WIDTH-1:0]  irq_mask_next;
    logic [IN_WIDTH-1:0]  edge_cap_reg;
    logic [IN_WIDTH-1:0]  edge_cap_next;
    logic                 irq_reg;
    logic                 irq_next;
    logic [BUS_WIDTH-1:0] readdata_reg;
    logic [BUS_WIDTH-1:0] readdata_next;
    logic                 readdatavalid_reg;
    logic [BUS_WIDTH-1:0] read_mux;

    reg_addr_e            addr;
    logic [OUT_WIDTH-1:0] wdata_out;
    logic [IN_WIDTH-1:0]  wdata_in;
    logic [IN_WIDTH-1:0]  cap_clear;
    logic                 unused_wdata;

    generate
        for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_chan
            pio_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .EDGE_MODE      (EDGE_MODE)
            ) u_debounce (
                .clk     (clk_clk),
                .srst    (reset_reset),
                .din     (pio_in_export[gi]),
                .deb     (data_in[gi]),
                .edge_evt(edge_evt[gi])
            );
        end
    endgenerate

    assign addr         = reg_addr_e'(avs_address);
    assign wdata_out    = avs_writedata[OUT_WIDTH-1:0];
    assign wdata_in     = avs_writedata[IN_WIDTH-1:0];
    // Bits above the register widths are intentionally dropped.
    assign unused_wdata = ^avs_writedata;

    always_comb begin
        data_out_next = data_out_reg;
        irq_mask_next = irq_mask_reg;
        cap_clear     = '0;
        if (avs_write) begin
            case (addr)
                ADDR_DATA_OUT: data_out_next = wdata_out;
                ADDR_IRQ_MASK: irq_mask_next = wdata_in;
                ADDR_EDGE_CAP: cap_clear     = wdata_in;
                ADDR_OUT_SET:  data_out_next = data_out_reg | wdata_out;
                ADDR_OUT_CLR:  data_out_next = data_out_reg & ~wdata_out;
                default:       ;
            endcase
        end
    end

    // A new edge is OR-ed in after the clear, so a simultaneous event survives the W1C.
    assign edge_cap_next = (edge_cap_reg & ~cap_clear) | edge_evt;
    assign irq_next      = |(edge_cap_reg & irq_mask_reg);

    always_comb begin
        read_mux = '0;
        case (addr)
            ADDR_DATA_IN:  read_mux = BUS_WIDTH'(data_in);
            ADDR_DATA_OUT: read_mux = BUS_WIDTH'(data_out_reg);
            ADDR_IRQ_MASK: read_mux = BUS_WIDTH'(irq_mask_reg);
            ADDR_EDGE_CAP: read_mux = BUS_WIDTH'(edge_cap_reg);
            default:       read_mux = '0;
        endcase
    end

    assign readdata_next = avs_read ? read_mux : readdata_reg;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            data_out_reg      <= '0;
            irq_mask_reg      <= '0;
            edge_cap_reg      <= '0;
            irq_reg           <= 1'b0;
            readdata_reg      <= '0;
            readdatavalid_reg <= 1'b0;
        end else begin
            data_out_reg      <= data_out_next;
            irq_mask_reg      <= irq_mask_next;
            edge_cap_reg      <= edge_cap_next;
            irq_reg           <= irq_next;
            readdata_reg      <= readdata_next;
            readdatavalid_reg <= avs_read;
        end
    end

    assign pio_out_export    = data_out_reg;
    assign avs_readdata      = readdata_reg;
    assign avs_readdatavalid = readdatavalid_reg;
    assign irq               = irq_reg;

endmodule

// File: tb/tb_pio_io_ctrl.sv
// Directed bench for pio_io_ctrl with DEBOUNCE_CYCLES=4, rising-edge capture.
module tb_pio_io_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  pin = 3'b000;
    logic [7:0]  pout;
    logic [2:0]  addr = 3'd0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    pio_io_ctrl #(
        .IN_WIDTH       (3),
        .OUT_WIDTH      (8),
        .DEBOUNCE_CYCLES(4),
        .EDGE_MODE      (0)
    ) dut (
        .clk_clk          (clk),
        .reset_reset      (rst),
        .pio_in_export    (pin),
        .pio_out_export   (pout),
        .avs_address      (addr),
        .avs_read         (rd),
        .avs_write        (wr),
        .avs_writedata    (wdata),
        .avs_readdata     (rdata),
        .avs_readdatavalid(rvalid),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        tick();
        wr    = 1'b0;
        $display("write addr=%0d data=0x%08h", a, d);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic v);
        addr = a;
        rd   = 1'b1;
        tick();
        rd   = 1'b0;
        d    = rdata;
        v    = rvalid;
        $display("read  addr=%0d data=0x%08h valid=%b", a, d, v);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        rst = 1'b1;
        repeat (3) tick();
        checks += 4;
        if (pout !== 8'h00)  begin failures++; $display("FAIL reset_pout got=0x%02h exp=0x00", pout); end
        if (rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=0x%08h exp=0", rdata); end
        if (rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
        if (irq !== 1'b0)    begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        rst = 1'b0;
        tick();
        bus_read(3'd0, d, v);
        checks += 2;
        if (v !== 1'b1)      begin failures++; $display("FAIL reset_read_valid got=%b exp=1", v); end
        if (d !== 32'd0)     begin failures++; $display("FAIL reset_data_in got=0x%08h exp=0", d); end
    endtask

    task automatic test_debounce_step();
        logic [31:0] d;
        logic        v;
        pin[0] = 1'b1;
        addr   = 3'd0;
        rd     = 1'b1;
        // readdata after edge k reflects the debounced value after edge k-1
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) begin
                checks++;
                if (rdata !== 32'd0) begin failures++; $display("FAIL deb_early got=0x%08h exp=0", rdata); end
            end
            if (k == 7) begin
                checks += 2;
                if (rdata !== 32'd1) begin failures++; $display("FAIL deb_latency got=0x%08h exp=1", rdata); end
                if (rvalid !== 1'b1) begin failures++; $display("FAIL deb_rvalid got=%b exp=1", rvalid); end
            end
        end
        rd = 1'b0;
        tick();
        checks += 2;
        if (rvalid !== 1'b0) begin failures++; $display("FAIL valid_drop got=%b exp=0", rvalid); end
        if (rdata !== 32'd1) begin failures++; $display("FAIL rdata_hold got=0x%08h exp=1", rdata); end
        bus_read(3'd3, d, v);
        checks += 2;
        if (d !== 32'd1) begin failures++; $display("FAIL step_edge_cap got=0x%08h exp=1", d); end
        if (irq !== 1'b0) begin failures++; $display("FAIL step_irq_masked got=%b exp=0", irq); end
        bus_write(3'd3, 32'd1);
        bus_read(3'd3, d, v);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL step_w1c got=0x%08h exp=0", d); end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic        v;
        logic        irq_seen;
        bus_write(3'd2, 32'd7);
        pin[1] = 1'b1;
        repeat (3) tick();
        pin[1] = 1'b0;
        irq_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (irq !== 1'b0) irq_seen = 1'b1;
        end
        checks++;
        if (irq_seen !== 1'b0) begin failures++; $display("FAIL glitch_irq got=1 exp=0"); end
        bus_read(3'd0, d, v);
        checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL glitch_data_in got=0x%08h exp=1", d); end
        bus_read(3'd3, d, v);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL glitch_edge_cap got=0x%08h exp=0", d); end
        bus_write(3'd2, 32'd0);
    endtask

    task automatic test_out_regs();
        logic [31:0] d;
        logic        v;
        bus_write(3'd1, 32'h0000_00A5);
        checks++;
        if (pout !== 8'hA5) begin failures++; $display("FAIL out_write got=0x%02h exp=0xa5", pout); end
        bus_write(3'd4, 32'h0000_000F);
        checks++;
        if (pout !== 8'hAF) begin failures++; $display("FAIL out_set got=0x%02h exp=0xaf", pout); end
        bus_write(3'd5, 32'h0000_0081);
        checks++;
        if (pout !== 8'h2E) begin failures++; $display("FAIL out_clr got=0x%02h exp=0x2e", pout); end
        bus_read(3'd1, d, v);
        checks++;
        if (d !== 32'h0000_002E) begin failures++; $display("FAIL out_readback got=0x%08h exp=0x0000002e", d); end
        bus_write(3'd1, 32'hDEAD_BE5A);
        bus_read(3'd1, d, v);
        checks++;
        if (d !== 32'h0000_005A) begin failures++; $display("FAIL out_upper_ignored got=0x%08h exp=0x0000005a", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic        v;
        bus_write(3'd2, 32'd1);
        pin[0] = 1'b0;
        repeat (10) tick();
        bus_read(3'd3, d, v);
        checks += 2;
        if (d !== 32'd0)  begin failures++; $display("FAIL falling_ignored got=0x%08h exp=0", d); end
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_idle got=%b exp=0", irq); end
        pin[0] = 1'b1;
        repeat (10) tick();
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_assert got=%b exp=1", irq); end
        bus_write(3'd3, 32'd1);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_hold got=%b exp=1", irq); end
        tick();
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq); end
        // Line the W1C up with the edge pulse: both are sampled on edge 7 after the step.
        pin[0] = 1'b0;
        repeat (10) tick();
        pin[0] = 1'b1;
        repeat (6) tick();
        addr  = 3'd3;
        wdata = 32'd1;
        wr    = 1'b1;
        tick();
        wr    = 1'b0;
        bus_read(3'd3, d, v);
        checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL set_beats_clear got=0x%08h exp=1", d); end
        tick();
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_after_race got=%b exp=1", irq); end
        bus_write(3'd3, 32'd1);
        bus_write(3'd2, 32'd0);
    endtask

    task automatic test_reserved();
        logic [31:0] d;
        logic        v;
        bus_read(3'd6, d, v);
        checks += 2;
        if (d !== 32'd0) begin failures++; $display("FAIL rsvd_data got=0x%08h exp=0", d); end
        if (v !== 1'b1)  begin failures++; $display("FAIL rsvd_valid got=%b exp=1", v); end
        tick();
        checks++;
        if (rvalid !== 1'b0) begin failures++; $display("FAIL rsvd_valid_once got=%b exp=0", rvalid); end
        bus_read(3'd4, d, v);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL wo_reads_zero got=0x%08h exp=0", d); end
        bus_write(3'd0, 32'hFF);
        bus_read(3'd0, d, v);
        checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL ro_write_ignored got=0x%08h exp=1", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        v;
        pin[2] = 1'b1;
        repeat (3) tick();
        rst  = 1'b1;
        addr = 3'd0;
        rd   = 1'b1;
        tick();
        checks += 4;
        if (rvalid !== 1'b0) begin failures++; $display("FAIL rst_read_valid got=%b exp=0", rvalid); end
        if (rdata !== 32'd0) begin failures++; $display("FAIL rst_rdata got=0x%08h exp=0", rdata); end
        if (pout !== 8'h00)  begin failures++; $display("FAIL rst_pout got=0x%02h exp=0", pout); end
        if (irq !== 1'b0)    begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) begin
                checks++;
                if (rdata !== 32'd0) begin failures++; $display("FAIL rst_discard got=0x%08h exp=0", rdata); end
            end
            if (k == 7) begin
                checks++;
                if (rdata !== 32'd5) begin failures++; $display("FAIL rst_release_deb got=0x%08h exp=5", rdata); end
            end
        end
        rd = 1'b0;
        tick();
        bus_read(3'd3, d, v);
        checks++;
        if (d !== 32'd5) begin failures++; $display("FAIL rst_release_edge got=0x%08h exp=5", d); end
    endtask

    initial begin
        test_reset();
        test_debounce_step();
        test_glitch();
        test_out_regs();
        test_irq();
        test_reserved();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
